// File: rtl/obstacles_on_screen.sv
// Per-frame obstacle culling filter: tracks each vertex burst's bounding box, keeps
// bursts that overlap the camera window, and publishes them through a double-buffered table.
module obstacles_on_screen #(
  parameter int unsigned WORLD_BITS              = 32,
  parameter int unsigned MAX_NUM_VERTICES        = 8,
  parameter int unsigned MAX_OBSTACLES_ON_SCREEN = 8,
  parameter int unsigned SCREEN_WIDTH            = 1280,
  parameter int unsigned SCREEN_HEIGHT           = 720
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic                                         valid_in,
  input  logic signed [WORLD_BITS-1:0]                 x_in,
  input  logic signed [WORLD_BITS-1:0]                 y_in,
  input  logic                                         done_in,
  input  logic signed [WORLD_BITS-1:0]                 camera_x_in,
  input  logic signed [WORLD_BITS-1:0]                 camera_y_in,
  input  logic [$clog2(MAX_OBSTACLES_ON_SCREEN)-1:0]   rd_obs_idx_in,
  input  logic [$clog2(MAX_NUM_VERTICES)-1:0]          rd_vtx_idx_in,
  output logic signed [WORLD_BITS-1:0]                 rd_x_out,
  output logic signed [WORLD_BITS-1:0]                 rd_y_out,
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]        rd_num_vertices_out,
  output logic [$clog2(MAX_OBSTACLES_ON_SCREEN+1)-1:0] num_obstacles_out,
  output logic                                         frame_valid_out,
  output logic                                         obs_overflow_out,
  output logic                                         vtx_truncated_out
);

  localparam int unsigned W   = WORLD_BITS;
  localparam int unsigned MO  = MAX_OBSTACLES_ON_SCREEN;
  localparam int unsigned MV  = MAX_NUM_VERTICES;
  localparam int unsigned OIW = $clog2(MO);
  localparam int unsigned VIW = $clog2(MV);
  localparam int unsigned NVW = $clog2(MV + 1);
  localparam int unsigned CW  = $clog2(MO + 1);

  localparam logic [NVW-1:0]    NV_MAX  = NVW'(MV);
  localparam logic [CW-1:0]     CNT_MAX = CW'(MO);
  localparam logic signed [W:0] X_SPAN  = (WORLD_BITS+1)'(SCREEN_WIDTH - 1);
  localparam logic signed [W:0] Y_SPAN  = (WORLD_BITS+1)'(SCREEN_HEIGHT - 1);

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } vertex_t;

  typedef enum logic {S_IDLE, S_OPEN} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] min_x_q, max_x_q, min_y_q, max_y_q;
  logic signed [W-1:0] min_x_c, max_x_c, min_y_c, max_y_c;
  logic [NVW-1:0]      vtx_cnt_q, n_cur_c, n_eff_c;
  logic [CW-1:0]       wr_count_q, wr_count_c;
  logic                wr_bank_q, rd_bank_c;
  logic                wr_ovf_q, wr_trunc_q, ovf_c, trunc_c;
  logic                first_c, trunc_now_c, close_c, visible_c, slot_free_c, commit_c, drop_c;
  logic signed [W:0]   cam_x_hi_c, cam_y_hi_c, min_x_ext_c, min_y_ext_c;

  vertex_t        vtx_mem [2][MO][MV];
  logic [NVW-1:0] nv_mem  [2][MO];

  // Window far edges and widened minima so the inclusive-edge tests cannot wrap
  assign cam_x_hi_c  = $signed({camera_x_in[W-1], camera_x_in}) + X_SPAN;
  assign cam_y_hi_c  = $signed({camera_y_in[W-1], camera_y_in}) + Y_SPAN;
  assign min_x_ext_c = $signed({min_x_c[W-1], min_x_c});
  assign min_y_ext_c = $signed({min_y_c[W-1], min_y_c});
  assign rd_bank_c   = ~wr_bank_q;

  // Burst tracking FSM, running bounds and close/commit decisions
  always_comb begin
    state_d     = state_q;
    first_c     = (state_q == S_IDLE);
    n_cur_c     = first_c ? '0 : vtx_cnt_q;
    n_eff_c     = n_cur_c;
    trunc_now_c = 1'b0;
    min_x_c     = min_x_q;
    max_x_c     = max_x_q;
    min_y_c     = min_y_q;
    max_y_c     = max_y_q;
    if (valid_in) begin
      if (first_c) begin
        min_x_c = x_in;
        max_x_c = x_in;
        min_y_c = y_in;
        max_y_c = y_in;
      end else begin
        if (x_in < min_x_q) min_x_c = x_in;
        if (x_in > max_x_q) max_x_c = x_in;
        if (y_in < min_y_q) min_y_c = y_in;
        if (y_in > max_y_q) max_y_c = y_in;
      end
      if (n_cur_c < NV_MAX) n_eff_c = n_cur_c + NVW'(1);
      else                  trunc_now_c = 1'b1;
    end
    close_c     = done_in ? (valid_in || !first_c) : (!first_c && !valid_in);
    state_d     = (valid_in && !done_in) ? S_OPEN : S_IDLE;
    visible_c   = (max_x_c >= camera_x_in) && (min_x_ext_c <= cam_x_hi_c) &&
                  (max_y_c >= camera_y_in) && (min_y_ext_c <= cam_y_hi_c);
    slot_free_c = (wr_count_q < CNT_MAX);
    commit_c    = close_c && visible_c && slot_free_c;
    drop_c      = close_c && visible_c && !slot_free_c;
    wr_count_c  = wr_count_q + CW'(commit_c);
    ovf_c       = wr_ovf_q | drop_c;
    trunc_c     = wr_trunc_q | trunc_now_c;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Bounds, write-bank bookkeeping and frame publication
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      min_x_q           <= '0;
      max_x_q           <= '0;
      min_y_q           <= '0;
      max_y_q           <= '0;
      vtx_cnt_q         <= '0;
      wr_bank_q         <= 1'b0;
      wr_count_q        <= '0;
      wr_ovf_q          <= 1'b0;
      wr_trunc_q        <= 1'b0;
      num_obstacles_out <= '0;
      obs_overflow_out  <= 1'b0;
      vtx_truncated_out <= 1'b0;
      frame_valid_out   <= 1'b0;
    end else begin
      if (valid_in) begin
        min_x_q   <= min_x_c;
        max_x_q   <= max_x_c;
        min_y_q   <= min_y_c;
        max_y_q   <= max_y_c;
        vtx_cnt_q <= n_eff_c;
      end
      frame_valid_out <= done_in;
      if (done_in) begin
        num_obstacles_out <= wr_count_c;
        obs_overflow_out  <= ovf_c;
        vtx_truncated_out <= trunc_c;
        wr_bank_q         <= ~wr_bank_q;
        wr_count_q        <= '0;
        wr_ovf_q          <= 1'b0;
        wr_trunc_q        <= 1'b0;
      end else begin
        wr_count_q <= wr_count_c;
        wr_ovf_q   <= ovf_c;
        wr_trunc_q <= trunc_c;
      end
    end
  end

  // Table storage; contents are only meaningful below the recorded counts
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      if (valid_in && slot_free_c && (n_cur_c < NV_MAX))
        vtx_mem[wr_bank_q][wr_count_q[OIW-1:0]][n_cur_c[VIW-1:0]] <= '{x: x_in, y: y_in};
      if (commit_c)
        nv_mem[wr_bank_q][wr_count_q[OIW-1:0]] <= n_eff_c;
    end
  end

  // Registered read port from the published bank; unused entries read as zero
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_x_out            <= '0;
      rd_y_out            <= '0;
      rd_num_vertices_out <= '0;
    end else begin
      rd_x_out            <= '0;
      rd_y_out            <= '0;
      rd_num_vertices_out <= '0;
      if (CW'(rd_obs_idx_in) < num_obstacles_out) begin
        rd_num_vertices_out <= nv_mem[rd_bank_c][rd_obs_idx_in];
        if (NVW'(rd_vtx_idx_in) < nv_mem[rd_bank_c][rd_obs_idx_in]) begin
          rd_x_out <= vtx_mem[rd_bank_c][rd_obs_idx_in][rd_vtx_idx_in].x;
          rd_y_out <= vtx_mem[rd_bank_c][rd_obs_idx_in][rd_vtx_idx_in].y;
        end
      end
    end
  end

endmodule

// File: tb/tb_obstacles_on_screen.sv
// Randomized scoreboard bench for obstacles_on_screen against a list-based frame model.
module tb_obstacles_on_screen;

  localparam int W   = 32;
  localparam int MV  = 8;
  localparam int MO  = 8;
  localparam int SW  = 1280;
  localparam int SH  = 720;
  localparam int OIW = $clog2(MO);
  localparam int VIW = $clog2(MV);
  localparam int NVW = $clog2(MV + 1);
  localparam int CW  = $clog2(MO + 1);

  logic                clk_in = 1'b0;
  logic                rst_in, valid_in, done_in;
  logic signed [W-1:0] x_in, y_in, camera_x_in, camera_y_in;
  logic [OIW-1:0]      rd_obs_idx_in;
  logic [VIW-1:0]      rd_vtx_idx_in;
  logic signed [W-1:0] rd_x_out, rd_y_out;
  logic [NVW-1:0]      rd_num_vertices_out;
  logic [CW-1:0]       num_obstacles_out;
  logic                frame_valid_out, obs_overflow_out, vtx_truncated_out;

  obstacles_on_screen dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .x_in(x_in), .y_in(y_in),
    .done_in(done_in), .camera_x_in(camera_x_in), .camera_y_in(camera_y_in),
    .rd_obs_idx_in(rd_obs_idx_in), .rd_vtx_idx_in(rd_vtx_idx_in),
    .rd_x_out(rd_x_out), .rd_y_out(rd_y_out), .rd_num_vertices_out(rd_num_vertices_out),
    .num_obstacles_out(num_obstacles_out), .frame_valid_out(frame_valid_out),
    .obs_overflow_out(obs_overflow_out), .vtx_truncated_out(vtx_truncated_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int cnt; bit ovf; bit trunc; } frame_t;
  typedef struct { longint x; longint y; int nv; } rd_t;

  frame_t frameq[$];
  rd_t    rdq[$];
  frame_t fe;
  rd_t    re;
  int     vectors = 0;
  int     miscompares = 0;
  bit     rd_req = 1'b0;
  bit     rd_pend = 1'b0;

  // Frame model: obstacles accepted into the frame being filled, and the published one
  longint cur_x[MO][MV], cur_y[MO][MV], pub_x[MO][MV], pub_y[MO][MV];
  int     cur_nv[MO], pub_nv[MO];
  int     cur_cnt = 0, pub_cnt = 0;
  bit     cur_ovf = 1'b0, cur_trunc = 1'b0;
  longint cam_x = 0, cam_y = 0;
  longint bx[16], by[16];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_in) rd_pend <= rd_req;

  // Monitor: pops an expectation whenever the DUT presents a frame or read result
  always @(negedge clk_in) begin
    if (frame_valid_out) begin
      if (frameq.size() == 0) chk("frame_unexpected", 1, 0);
      else begin
        fe = frameq.pop_front();
        chk("frame_cnt", longint'(num_obstacles_out), fe.cnt);
        chk("frame_ovf", longint'(obs_overflow_out), fe.ovf);
        chk("frame_trunc", longint'(vtx_truncated_out), fe.trunc);
      end
    end
    if (rd_pend) begin
      if (rdq.size() == 0) chk("read_unexpected", 1, 0);
      else begin
        re = rdq.pop_front();
        chk("rd_x", longint'(rd_x_out), re.x);
        chk("rd_y", longint'(rd_y_out), re.y);
        chk("rd_nv", longint'(rd_num_vertices_out), re.nv);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_cam(input longint cx, input longint cy);
    cam_x = cx;
    cam_y = cy;
    camera_x_in = 32'(cx);
    camera_y_in = 32'(cy);
  endtask

  task automatic model_close(input int n);
    longint mnx, mxx, mny, mxy;
    int k;
    mnx = bx[0]; mxx = bx[0]; mny = by[0]; mxy = by[0];
    for (int i = 1; i < n; i++) begin
      if (bx[i] < mnx) mnx = bx[i];
      if (bx[i] > mxx) mxx = bx[i];
      if (by[i] < mny) mny = by[i];
      if (by[i] > mxy) mxy = by[i];
    end
    if (n > MV) cur_trunc = 1'b1;
    if (mxx >= cam_x && mnx <= cam_x + SW - 1 && mxy >= cam_y && mny <= cam_y + SH - 1) begin
      if (cur_cnt < MO) begin
        k = (n < MV) ? n : MV;
        cur_nv[cur_cnt] = k;
        for (int i = 0; i < k; i++) begin
          cur_x[cur_cnt][i] = bx[i];
          cur_y[cur_cnt][i] = by[i];
        end
        cur_cnt++;
      end else cur_ovf = 1'b1;
    end
  endtask

  task automatic model_publish();
    frame_t f;
    f.cnt = cur_cnt; f.ovf = cur_ovf; f.trunc = cur_trunc;
    frameq.push_back(f);
    pub_x = cur_x; pub_y = cur_y; pub_nv = cur_nv; pub_cnt = cur_cnt;
    cur_cnt = 0; cur_ovf = 1'b0; cur_trunc = 1'b0;
  endtask

  task automatic burst(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      x_in = 32'(bx[i]);
      y_in = 32'(by[i]);
      done_in = done_last && (i == n - 1);
      step();
    end
    valid_in = 1'b0;
    done_in = 1'b0;
    model_close(n);
    if (done_last) model_publish();
    step();
  endtask

  task automatic done_pulse();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    model_publish();
  endtask

  task automatic read_all();
    rd_t e;
    int nv;
    for (int o = 0; o < MO; o++) begin
      nv = (o < pub_cnt) ? pub_nv[o] : 0;
      for (int v = 0; v < ((nv > 0) ? nv : 1); v++) begin
        rd_obs_idx_in = OIW'(o);
        rd_vtx_idx_in = VIW'(v);
        e.nv = nv;
        e.x = (o < pub_cnt) ? pub_x[o][v] : 0;
        e.y = (o < pub_cnt) ? pub_y[o][v] : 0;
        rdq.push_back(e);
        rd_req = 1'b1;
        step();
      end
    end
    rd_req = 1'b0;
    step();
    step();
  endtask

  task automatic load4a();
    bx[0] = 'hAA; by[0] = 'hBB; bx[1] = 'hCC; by[1] = 'hDD;
    bx[2] = 'hEE; by[2] = 'hFF; bx[3] = 'h88; by[3] = 'h99;
  endtask

  task automatic load5b();
    bx[0] = 'hA0; by[0] = 'hB0; bx[1] = 'hC0; by[1] = 'hD0; bx[2] = 'hE0; by[2] = 'hF0;
    bx[3] = 'h80; by[3] = 'h90; bx[4] = 'h60; by[4] = 'h70;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nobs, n;
    bit dl;
    rst_in = 1'b0; valid_in = 1'b0; done_in = 1'b0; x_in = '0; y_in = '0;
    rd_obs_idx_in = '0; rd_vtx_idx_in = '0;
    set_cam(0, 0);
    repeat (3) step();
    chk("reset_frame_valid", longint'(frame_valid_out), 0);
    chk("reset_count", longint'(num_obstacles_out), 0);
    chk("reset_ovf", longint'(obs_overflow_out), 0);
    chk("reset_trunc", longint'(vtx_truncated_out), 0);
    chk("reset_rd_x", longint'(rd_x_out), 0);
    chk("reset_rd_y", longint'(rd_y_out), 0);
    chk("reset_rd_nv", longint'(rd_num_vertices_out), 0);
    rst_in = 1'b1;
    step();

    // Empty frame
    done_pulse();
    step();
    read_all();

    // Two obstacles, camera at origin
    load4a(); burst(4, 1'b0);
    repeat (2) step();
    load5b(); burst(5, 1'b0);
    done_pulse();
    step();
    read_all();

    // Next frame: previous frame stays readable until done
    load5b(); burst(3, 1'b0);
    read_all();
    done_pulse();
    step();
    read_all();

    // Off-screen, then an inclusive-edge hit
    set_cam(10000, 10000);
    load4a(); burst(4, 1'b0);
    load5b(); burst(5, 1'b0);
    done_pulse();
    step();
    set_cam(-1279, 0);
    bx[0] = 0; by[0] = 5; burst(1, 1'b0);
    done_pulse();
    step();
    read_all();

    // Vertex truncation and obstacle overflow
    set_cam(0, 0);
    for (int i = 0; i < 10; i++) begin bx[i] = 10 * i + 1; by[i] = 7 * i - 3; end
    burst(10, 1'b0);
    done_pulse();
    step();
    read_all();
    for (int i = 0; i < 9; i++) begin bx[0] = 5; by[0] = 5; burst(1, 1'b0); end
    done_pulse();
    step();
    read_all();

    // done_in coincident with the last vertex
    load5b(); burst(3, 1'b1);
    step();
    read_all();

    // Reset in the middle of a burst
    load4a(); burst(2, 1'b0);
    valid_in = 1'b1; x_in = 32'(bx[0]); y_in = 32'(by[0]); step();
    rst_in = 1'b0; step();
    rst_in = 1'b1; valid_in = 1'b0;
    cur_cnt = 0; cur_ovf = 1'b0; cur_trunc = 1'b0; pub_cnt = 0;
    chk("rst_mid_count", longint'(num_obstacles_out), 0);
    step();
    done_pulse();
    step();
    read_all();

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      set_cam(longint'($urandom_range(200000)) - 100000, longint'($urandom_range(200000)) - 100000);
      nobs = int'($urandom_range(11));
      dl = 1'b0;
      for (int o = 0; o < nobs; o++) begin
        n = int'($urandom_range(10, 1));
        for (int i = 0; i < n; i++) begin
          bx[i] = cam_x + longint'($urandom_range(4000)) - 1500;
          by[i] = cam_y + longint'($urandom_range(2400)) - 900;
        end
        dl = (o == nobs - 1) && ($urandom_range(3) == 0);
        burst(n, dl);
        repeat (int'($urandom_range(2))) step();
      end
      if (!dl) done_pulse();
      step();
      read_all();
    end

    repeat (4) step();
    if (frameq.size() != 0) chk("frame_pending", frameq.size(), 0);
    if (rdq.size() != 0) chk("read_pending", rdq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
